// File: rtl/intan_spi_master.sv
// SPI mode-0 master for Intan RHD/RHS chips: one 16-bit word per CS_n frame,
// full duplex, with a fixed CS_n-high gap between frames.
module intan_spi_master #(
  parameter int CLK_DIV = 2,
  parameter int CS_HIGH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_valid,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_HIGH - 1);
  localparam logic [4:0] BIT_LAST = 5'd15;

  state_t      state, state_n;
  logic [7:0]  div_cnt, div_cnt_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [14:0] tx_sr, tx_sr_n;   // bits still to send after the one on mosi
  logic [15:0] rx_sr, rx_sr_n;
  logic        cs_n_q, cs_n_n;
  logic        sclk_q, sclk_n;
  logic        mosi_q, mosi_n;
  logic        ready_q, ready_n;
  logic        busy_q, busy_n;
  logic        rsp_valid_q, rsp_valid_n;
  logic [15:0] rsp_data_q, rsp_data_n;

  // NOTE: every variable gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    div_cnt_n   = div_cnt;
    bit_cnt_n   = bit_cnt;
    tx_sr_n     = tx_sr;
    rx_sr_n     = rx_sr;
    cs_n_n      = cs_n_q;
    sclk_n      = sclk_q;
    mosi_n      = mosi_q;
    ready_n     = ready_q;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data_q;

    unique case (state)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          state_n   = SHIFT;
          ready_n   = 1'b0;
          cs_n_n    = 1'b0;
          sclk_n    = 1'b0;
          mosi_n    = cmd_data[15];
          tx_sr_n   = cmd_data[14:0];
          div_cnt_n = '0;
          bit_cnt_n = '0;
        end
      end

      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = '0;
          if (!sclk_q) begin
            sclk_n  = 1'b1;
            rx_sr_n = {rx_sr[14:0], spi_miso};
          end else begin
            sclk_n = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state_n   = TAIL;
              mosi_n    = 1'b0;
              bit_cnt_n = '0;
            end else begin
              bit_cnt_n = bit_cnt + 5'd1;
              mosi_n    = tx_sr[14];
              tx_sr_n   = {tx_sr[13:0], 1'b0};
            end
          end
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end

      // Hold CS_n low one half-period past the last falling SCLK edge.
      TAIL: begin
        if (div_cnt == DIV_LAST) begin
          state_n     = GAP;
          div_cnt_n   = '0;
          cs_n_n      = 1'b1;
          rsp_data_n  = rx_sr;
          rsp_valid_n = 1'b1;
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end

      GAP: begin
        if (div_cnt == GAP_LAST) begin
          state_n   = IDLE;
          div_cnt_n = '0;
          ready_n   = 1'b1;
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state       <= state_n;
      div_cnt     <= div_cnt_n;
      bit_cnt     <= bit_cnt_n;
      tx_sr       <= tx_sr_n;
      rx_sr       <= rx_sr_n;
      cs_n_q      <= cs_n_n;
      sclk_q      <= sclk_n;
      mosi_q      <= mosi_n;
      ready_q     <= ready_n;
      busy_q      <= busy_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_intan_spi_master.sv
// Directed bench for intan_spi_master: three instances cover the default and
// two swept parameter sets, each with its own behavioural SPI slave.
module tb_intan_spi_master;

  localparam int N = 3;
  localparam int DIVS [N] = '{2, 1, 5};
  localparam int CSHS [N] = '{8, 2, 8};

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [15:0]   cmd_data = '0;
  logic [N-1:0]  cmd_valid = '0;
  logic [N-1:0]  cmd_ready, rsp_valid, busy, cs_n, sclk, mosi, miso;
  logic [15:0]   rsp_data [N];
  logic [15:0]   slave_word [N];
  logic [15:0]   cap_a [N];
  int            pulses_a [N];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gs
    intan_spi_master #(.CLK_DIV(DIVS[g]), .CS_HIGH(CSHS[g])) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_data  (cmd_data),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .rsp_data  (rsp_data[g]),
      .rsp_valid (rsp_valid[g]),
      .busy      (busy[g]),
      .spi_cs_n  (cs_n[g]),
      .spi_sclk  (sclk[g]),
      .spi_mosi  (mosi[g]),
      .spi_miso  (miso[g])
    );

    // Mode-0 slave: presents MSB when CS_n falls, advances after each rising edge.
    int          idx = -1;
    int          pulses = 0;
    logic [15:0] cap = '0;
    always @(negedge cs_n[g]) begin
      idx = 15;
      pulses = 0;
      cap = '0;
    end
    always @(posedge sclk[g]) begin
      cap = {cap[14:0], mosi[g]};
      pulses++;
      idx--;
    end
    assign miso[g]     = (idx >= 0) ? slave_word[g][idx[3:0]] : 1'b0;
    assign cap_a[g]    = cap;
    assign pulses_a[g] = pulses;
  end

  // One full transaction on instance k, with the cycle-by-cycle waveform
  // compared against the timing derived from CLK_DIV and CS_HIGH.
  task automatic run_word(input int k, input logic [15:0] cmd, input logic [15:0] sw,
                          input int inject, input bit release_rst);
    int d = DIVS[k];
    int csh = CSHS[k];
    int total = 33 * d + csh + 1;
    int rv_cyc = -1;
    int rdy_cyc = -1;
    int rv_cnt = 0;
    int wave_err = 0;
    logic exp_sclk, exp_cs, exp_busy, exp_ready;
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    slave_word[k] = sw;
    cmd_data = cmd;
    cmd_valid[k] = 1'b1;
    vectors++;
    if (cmd_ready[k] !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_accept[%0d]: got %b expected 1", k, cmd_ready[k]);
    end
    @(posedge clk);
    for (int c = 1; c <= total + 4; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid[k] = 1'b0;
      if (inject > 0 && c == inject) begin
        cmd_valid[k] = 1'b1;
        cmd_data = 16'h1234;
      end
      if (inject > 0 && c == inject + 1) cmd_valid[k] = 1'b0;
      exp_sclk  = (c <= 32 * d) && ((((c - 1) / d) % 2) == 1);
      exp_cs    = (c > 33 * d);
      exp_busy  = (c < total);
      exp_ready = (c >= total);
      if (sclk[k] !== exp_sclk || cs_n[k] !== exp_cs || busy[k] !== exp_busy ||
          cmd_ready[k] !== exp_ready || (c > 32 * d && mosi[k] !== 1'b0)) begin
        wave_err++;
        if (wave_err <= 3)
          $display("  cycle %0d inst %0d: sclk=%b cs_n=%b busy=%b ready=%b mosi=%b", c, k,
                   sclk[k], cs_n[k], busy[k], cmd_ready[k], mosi[k]);
      end
      if (rsp_valid[k] === 1'b1) begin
        rv_cnt++;
        if (rv_cyc < 0) rv_cyc = c;
      end
      if (cmd_ready[k] === 1'b1 && rdy_cyc < 0) rdy_cyc = c;
    end
    vectors++;
    if (wave_err != 0) begin
      miscompares++;
      $display("FAIL waveform[%0d]: got %0d bad cycles expected 0", k, wave_err);
    end
    vectors++;
    if (rv_cyc != 33 * d + 1) begin
      miscompares++;
      $display("FAIL rsp_valid_cycle[%0d]: got %0d expected %0d", k, rv_cyc, 33 * d + 1);
    end
    vectors++;
    if (rv_cnt != 1) begin
      miscompares++;
      $display("FAIL rsp_valid_pulses[%0d]: got %0d expected 1", k, rv_cnt);
    end
    vectors++;
    if (rdy_cyc != total) begin
      miscompares++;
      $display("FAIL ready_cycle[%0d]: got %0d expected %0d", k, rdy_cyc, total);
    end
    vectors++;
    if (rsp_data[k] !== sw) begin
      miscompares++;
      $display("FAIL rsp_data[%0d]: got %h expected %h", k, rsp_data[k], sw);
    end
    vectors++;
    if (cap_a[k] !== cmd) begin
      miscompares++;
      $display("FAIL mosi_word[%0d]: got %h expected %h", k, cap_a[k], cmd);
    end
    vectors++;
    if (pulses_a[k] != 16) begin
      miscompares++;
      $display("FAIL sclk_pulses[%0d]: got %0d expected 16", k, pulses_a[k]);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    vectors++;
    if ({cs_n, sclk, mosi, cmd_ready, busy, rsp_valid} !== {3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_outputs: got cs_n=%b sclk=%b mosi=%b ready=%b busy=%b rv=%b", cs_n, sclk,
               mosi, cmd_ready, busy, rsp_valid);
    end
    vectors++;
    if ({rsp_data[0], rsp_data[1], rsp_data[2]} !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_rsp_data: got %h %h %h expected 0000", rsp_data[0], rsp_data[1], rsp_data[2]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    run_word(0, 16'hE800, 16'h0049, 0, 1'b0);
  endtask

  task automatic test_ignored_cmd();
    run_word(0, 16'hA5C3, 16'h3C5A, 10, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3] = '{16'h8000, 16'h8101, 16'hFFFF};
    logic [15:0] resps [3] = '{16'h1357, 16'h2468, 16'h0F0F};
    int rv_cyc [3] = '{0, 0, 0};
    int n = 0;
    int rv_n = 0;
    int gap_cnt = 0;
    int data_err = 0;
    for (int c = 0; c < 240; c++) begin
      @(negedge clk);
      if (rsp_valid[0] === 1'b1) begin
        if (rv_n < 3) begin
          rv_cyc[rv_n] = c;
          if (rsp_data[0] !== resps[rv_n] || cap_a[0] !== words[rv_n] || pulses_a[0] != 16)
            data_err++;
        end
        rv_n++;
      end
      if (cs_n[0] === 1'b1 && busy[0] === 1'b1) gap_cnt++;
      if (cmd_ready[0] === 1'b1) begin
        if (n < 3) begin
          cmd_data = words[n];
          slave_word[0] = resps[n];
          cmd_valid[0] = 1'b1;
          n++;
        end else begin
          cmd_valid[0] = 1'b0;
        end
      end
    end
    cmd_valid[0] = 1'b0;
    vectors++;
    if (rv_n != 3) begin
      miscompares++;
      $display("FAIL b2b_pulses: got %0d expected 3", rv_n);
    end
    vectors++;
    if (rv_cyc[1] - rv_cyc[0] != 75) begin
      miscompares++;
      $display("FAIL b2b_spacing_1: got %0d expected 75", rv_cyc[1] - rv_cyc[0]);
    end
    vectors++;
    if (rv_cyc[2] - rv_cyc[1] != 75) begin
      miscompares++;
      $display("FAIL b2b_spacing_2: got %0d expected 75", rv_cyc[2] - rv_cyc[1]);
    end
    vectors++;
    if (gap_cnt != 24) begin
      miscompares++;
      $display("FAIL b2b_gap_cycles: got %0d expected 24", gap_cnt);
    end
    vectors++;
    if (data_err != 0) begin
      miscompares++;
      $display("FAIL b2b_words: got %0d bad words expected 0", data_err);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int rv_seen = 0;
    @(negedge clk);
    slave_word[0] = 16'hFFFF;
    cmd_data = 16'hE800;
    cmd_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    for (int i = 0; i < 200 && pulses_a[0] < 8; i++) @(negedge clk);
    vectors++;
    if (pulses_a[0] < 8) begin
      miscompares++;
      $display("FAIL mid_reset_wait: got %0d pulses expected 8", pulses_a[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (cs_n[0] !== 1'b1 || sclk[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_immediate: got cs_n=%b sclk=%b expected 1 0", cs_n[0], sclk[0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid[0] === 1'b1) rv_seen++;
    end
    vectors++;
    if (rv_seen != 0 || rsp_data[0] !== 16'h0000 || cmd_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_state: got rv=%0d rsp=%h ready=%b busy=%b expected 0 0000 1 0",
               rv_seen, rsp_data[0], cmd_ready[0], busy[0]);
    end
    run_word(0, 16'h0F0F, 16'h5A5A, 0, 1'b1);
  endtask

  task automatic test_param_sweep();
    run_word(1, 16'h5555, 16'hAAAA, 0, 1'b0);
    run_word(2, 16'hC3A5, 16'hAAAA, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) slave_word[i] = '0;
    test_reset();
    test_single_read();
    test_ignored_cmd();
    test_back_to_back();
    test_reset_mid_transfer();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
